// File: rtl/load_unit.sv
// ---------------------------------------------------------------------------
// load_unit
//
// Memory-stage load engine. Accepts one load per handshake, issues a single
// read on the data bus, extracts the addressed byte/half/word/dword from the
// returned 64-bit beat and sign- or zero-extends it to 64 bits. Only one load
// is outstanding at any time.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   req_valid/ready    load request handshake (ready only while idle)
//   req_addr           byte address of the load
//   req_msize          access size: 0=byte, 1=half, 2=word, 3=dword
//   req_unsigned       1 = zero-extend, 0 = sign-extend
//   flush              pipeline flush, aborts the current load
//   dreq_valid         bus read request valid
//   dreq_addr/size     latched address and size, stable while dreq_valid
//   dreq_strobe        always zero (reads only)
//   dresp_addr_ok      bus accepted the address
//   dresp_data_ok      read data valid this cycle
//   dresp_data         raw aligned 64-bit beat
//   rsp_valid/ready    result handshake, result held until rsp_ready
//   rsp_data           extended load result
//   rsp_misalign       address was misaligned for its size
// ---------------------------------------------------------------------------
module load_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_msize,
  input  logic              req_unsigned,
  input  logic              flush,

  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_misalign
);

  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;
  localparam logic [1:0] MSIZE8 = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t state;
  logic   unsigned_q;

  // An access is misaligned when any address bit below its natural
  // alignment is set.
  function automatic logic is_misaligned(input logic [2:0] a,
                                         input logic [1:0] sz);
    logic m;
    m = 1'b0;
    case (sz)
      MSIZE2:  m = a[0];
      MSIZE4:  m = (a[1:0] != 2'b00);
      MSIZE8:  m = (a[2:0] != 3'b000);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Pick the addressed field out of the beat by shifting it down to bit 0,
  // then extend from the field's MSB. Dword loads ignore the unsigned flag.
  function automatic logic [63:0] extract(input logic [63:0] beat,
                                          input logic [2:0]  s,
                                          input logic [1:0]  sz,
                                          input logic        uns);
    logic [63:0] shifted;
    logic [63:0] res;
    shifted = 64'd0;
    res     = 64'd0;
    case (sz)
      MSIZE1: begin
        shifted = beat >> {s, 3'b000};
        res = {{56{~uns & shifted[7]}}, shifted[7:0]};
      end
      MSIZE2: begin
        shifted = beat >> {s[2:1], 4'b0000};
        res = {{48{~uns & shifted[15]}}, shifted[15:0]};
      end
      MSIZE4: begin
        shifted = beat >> {s[2], 5'b00000};
        res = {{32{~uns & shifted[31]}}, shifted[31:0]};
      end
      default: res = beat;
    endcase
    return res;
  endfunction

  // Handshake and bus-valid outputs are decoded straight from the state so
  // they can never disagree with it.
  assign req_ready   = (state == IDLE);
  assign dreq_valid  = (state == REQ);
  assign rsp_valid   = (state == DONE);
  assign dreq_strobe = 8'h00;

  // Main load FSM. The request fields are latched on acceptance and held
  // until the next acceptance, which keeps dreq_addr/dreq_size stable for
  // the whole time dreq_valid is high. Flush paths that have already had
  // their address accepted but not yet seen data go through DRAIN so the
  // orphaned beat is swallowed instead of being taken for the next load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      dreq_addr    <= '0;
      dreq_size    <= MSIZE1;
      unsigned_q   <= 1'b0;
      rsp_data     <= '0;
      rsp_misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            dreq_addr  <= req_addr;
            dreq_size  <= req_msize;
            unsigned_q <= req_unsigned;
            if (is_misaligned(req_addr[2:0], req_msize)) begin
              rsp_misalign <= 1'b1;
              rsp_data     <= '0;
              state        <= DONE;
            end else begin
              rsp_misalign <= 1'b0;
              state        <= REQ;
            end
          end
        end

        REQ: begin
          if (flush) begin
            if (dresp_addr_ok && !dresp_data_ok)
              state <= DRAIN;
            else
              state <= IDLE;
          end else if (dresp_addr_ok && dresp_data_ok) begin
            rsp_data <= extract(dresp_data, dreq_addr[2:0], dreq_size, unsigned_q);
            state    <= DONE;
          end else if (dresp_addr_ok) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (flush) begin
            state <= dresp_data_ok ? IDLE : DRAIN;
          end else if (dresp_data_ok) begin
            rsp_data <= extract(dresp_data, dreq_addr[2:0], dreq_size, unsigned_q);
            state    <= DONE;
          end
        end

        DRAIN: begin
          if (dresp_data_ok)
            state <= IDLE;
        end

        DONE: begin
          if (rsp_ready || flush)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// ---------------------------------------------------------------------------
// tb_load_unit
//
// Directed testbench for load_unit. Each task drives one scenario and checks
// the outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_load_unit;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_msize;
  logic        req_unsigned;
  logic        flush;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_misalign;

  int n_compared;
  int n_mismatched;

  load_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_msize    (req_msize),
    .req_unsigned (req_unsigned),
    .flush        (flush),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data   (dresp_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_misalign (rsp_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one accepting edge.
  task automatic issue(input logic [63:0] a, input logic [1:0] sz, input logic uns);
    req_addr     = a;
    req_msize    = sz;
    req_unsigned = uns;
    req_valid    = 1'b1;
    tick();
    req_valid    = 1'b0;
  endtask

  // Return one beat with address and data accepted in the same cycle.
  task automatic beat_now(input logic [63:0] d);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = d;
    tick();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
  endtask

  // Consume the result.
  task automatic accept_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    n_compared++; if (req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_compared++; if (dreq_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_dreq_valid got=%b exp=0", dreq_valid); end
    n_compared++; if (rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_compared++; if (rsp_misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rsp_misalign got=%b exp=0", rsp_misalign); end
    n_compared++; if (rsp_data !== 64'd0) begin n_mismatched++; $display("[TB] FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    n_compared++; if (dreq_addr !== 64'd0 || dreq_size !== 2'd0) begin n_mismatched++; $display("[TB] FAIL reset_dreq_fields got=%h/%0d exp=0/0", dreq_addr, dreq_size); end
    n_compared++; if (dreq_strobe !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_strobe got=%h exp=00", dreq_strobe); end
    #2 resetn = 1'b1;
    tick();
  endtask

  task automatic test_byte();
    // lb 0x2003: byte 3 of the beat is 0x80
    issue(64'h2003, 2'd0, 1'b0);
    n_compared++; if (dreq_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lb_dreq_valid got=%b exp=1", dreq_valid); end
    n_compared++; if (dreq_addr !== 64'h2003) begin n_mismatched++; $display("[TB] FAIL lb_dreq_addr got=%h exp=2003", dreq_addr); end
    n_compared++; if (dreq_size !== 2'd0) begin n_mismatched++; $display("[TB] FAIL lb_dreq_size got=%0d exp=0", dreq_size); end
    n_compared++; if (req_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lb_req_ready got=%b exp=0", req_ready); end
    n_compared++; if (rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lb_early_rsp got=%b exp=0", rsp_valid); end
    beat_now(64'h0000_0000_8000_0000);
    n_compared++; if (rsp_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lb_rsp_valid got=%b exp=1", rsp_valid); end
    n_compared++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FF80) begin n_mismatched++; $display("[TB] FAIL lb_data got=%h exp=ffffffffffffff80", rsp_data); end
    n_compared++; if (rsp_misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lb_misalign got=%b exp=0", rsp_misalign); end
    accept_rsp();
    n_compared++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lb_release got=%b/%b exp=0/1", rsp_valid, req_ready); end

    issue(64'h2003, 2'd0, 1'b1);
    beat_now(64'h0000_0000_8000_0000);
    n_compared++; if (rsp_data !== 64'h80) begin n_mismatched++; $display("[TB] FAIL lbu_data got=%h exp=80", rsp_data); end
    accept_rsp();
  endtask

  task automatic test_word_dword();
    issue(64'h1004, 2'd2, 1'b0);
    beat_now(64'h89AB_CDEF_0123_4567);
    n_compared++; if (rsp_data !== 64'hFFFF_FFFF_89AB_CDEF) begin n_mismatched++; $display("[TB] FAIL lw_data got=%h exp=ffffffff89abcdef", rsp_data); end
    accept_rsp();

    issue(64'h1004, 2'd2, 1'b1);
    beat_now(64'h89AB_CDEF_0123_4567);
    n_compared++; if (rsp_data !== 64'h0000_0000_89AB_CDEF) begin n_mismatched++; $display("[TB] FAIL lwu_data got=%h exp=0000000089abcdef", rsp_data); end
    accept_rsp();

    issue(64'h1000, 2'd2, 1'b0);
    beat_now(64'h89AB_CDEF_0123_4567);
    n_compared++; if (rsp_data !== 64'h0000_0000_0123_4567) begin n_mismatched++; $display("[TB] FAIL lw_low_data got=%h exp=0000000001234567", rsp_data); end
    accept_rsp();

    issue(64'h1000, 2'd3, 1'b0);
    beat_now(64'h89AB_CDEF_0123_4567);
    n_compared++; if (rsp_data !== 64'h89AB_CDEF_0123_4567) begin n_mismatched++; $display("[TB] FAIL ld_data got=%h exp=89abcdef01234567", rsp_data); end
    accept_rsp();

    // the unsigned flag has no effect on a dword
    issue(64'h1008, 2'd3, 1'b1);
    beat_now(64'hF000_0000_0000_0001);
    n_compared++; if (rsp_data !== 64'hF000_0000_0000_0001) begin n_mismatched++; $display("[TB] FAIL ldu_data got=%h exp=f000000000000001", rsp_data); end
    accept_rsp();

    // lhu at offset 2 picks bits [31:16]
    issue(64'h1002, 2'd1, 1'b1);
    beat_now(64'h1111_2222_9876_5555);
    n_compared++; if (rsp_data !== 64'h9876) begin n_mismatched++; $display("[TB] FAIL lhu_data got=%h exp=9876", rsp_data); end
    accept_rsp();
  endtask

  task automatic test_misalign();
    issue(64'h1001, 2'd1, 1'b0);
    n_compared++; if (rsp_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mis_lh_rsp_valid got=%b exp=1", rsp_valid); end
    n_compared++; if (rsp_misalign !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mis_lh_flag got=%b exp=1", rsp_misalign); end
    n_compared++; if (rsp_data !== 64'd0) begin n_mismatched++; $display("[TB] FAIL mis_lh_data got=%h exp=0", rsp_data); end
    n_compared++; if (dreq_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mis_lh_dreq got=%b exp=0", dreq_valid); end
    accept_rsp();
    n_compared++; if (dreq_valid !== 1'b0 || req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mis_lh_after got=%b/%b exp=0/1", dreq_valid, req_ready); end

    issue(64'h1004, 2'd3, 1'b0);
    n_compared++; if (rsp_valid !== 1'b1 || rsp_misalign !== 1'b1 || dreq_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mis_ld got=%b/%b/%b exp=1/1/0", rsp_valid, rsp_misalign, dreq_valid); end
    accept_rsp();

    // an aligned load after a misaligned one clears the flag
    issue(64'h1002, 2'd1, 1'b0);
    beat_now(64'h0000_0000_0001_0000);
    n_compared++; if (rsp_misalign !== 1'b0 || rsp_data !== 64'h1) begin n_mismatched++; $display("[TB] FAIL mis_clear got=%b/%h exp=0/1", rsp_misalign, rsp_data); end
    accept_rsp();
  endtask

  task automatic test_stall_and_hold();
    int stable_err;
    stable_err = 0;
    issue(64'h1006, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (dreq_valid !== 1'b1 || dreq_addr !== 64'h1006 || dreq_size !== 2'd1) stable_err++;
      tick();
    end
    n_compared++; if (stable_err !== 0) begin n_mismatched++; $display("[TB] FAIL stall_dreq_stable got=%0d errors exp=0", stable_err); end
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    n_compared++; if (dreq_valid !== 1'b0 || rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_wait got=%b/%b exp=0/0", dreq_valid, rsp_valid); end
    dresp_data_ok = 1'b1;
    dresp_data    = 64'hBEEF_1234_5678_9ABC;
    tick();
    dresp_data_ok = 1'b0;
    dresp_data    = 64'h0;
    stable_err = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 64'hFFFF_FFFF_FFFF_BEEF) stable_err++;
      tick();
    end
    n_compared++; if (stable_err !== 0) begin n_mismatched++; $display("[TB] FAIL hold_rsp got=%0d errors exp=0", stable_err); end
    n_compared++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_BEEF) begin n_mismatched++; $display("[TB] FAIL lh_stall_data got=%h exp=ffffffffffffbeef", rsp_data); end
    accept_rsp();
  endtask

  task automatic test_flush();
    // flush while waiting for data
    issue(64'h1000, 2'd2, 1'b0);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_compared++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_wait_drain got=%b/%b exp=0/0", req_ready, rsp_valid); end
    tick();
    tick();
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h1234;
    tick();
    dresp_data_ok = 1'b0;
    n_compared++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_wait_done got=%b/%b exp=1/0", req_ready, rsp_valid); end

    // flush before address acceptance withdraws the request
    issue(64'h3000, 2'd3, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_compared++; if (dreq_valid !== 1'b0 || req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_req got=%b/%b exp=0/1", dreq_valid, req_ready); end

    // a request presented together with flush is not accepted
    req_valid = 1'b1;
    req_addr  = 64'h4000;
    req_msize = 2'd3;
    flush     = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    n_compared++; if (dreq_valid !== 1'b0 || req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_idle got=%b/%b exp=0/1", dreq_valid, req_ready); end
  endtask

  task automatic test_back_to_back();
    issue(64'h5001, 2'd0, 1'b1);
    beat_now(64'h0000_0000_0000_AB00);
    n_compared++; if (rsp_data !== 64'hAB) begin n_mismatched++; $display("[TB] FAIL b2b_first got=%h exp=ab", rsp_data); end
    // request held high while leaving DONE: must not be taken on that edge
    rsp_ready    = 1'b1;
    req_valid    = 1'b1;
    req_addr     = 64'h5008;
    req_msize    = 2'd3;
    req_unsigned = 1'b0;
    tick();
    rsp_ready = 1'b0;
    n_compared++; if (dreq_valid !== 1'b0 || req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_leave_done got=%b/%b exp=0/1", dreq_valid, req_ready); end
    tick();
    req_valid = 1'b0;
    n_compared++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h5008) begin n_mismatched++; $display("[TB] FAIL b2b_second got=%b/%h exp=1/5008", dreq_valid, dreq_addr); end
    beat_now(64'h0102_0304_0506_0708);
    n_compared++; if (rsp_data !== 64'h0102_0304_0506_0708) begin n_mismatched++; $display("[TB] FAIL b2b_second_data got=%h exp=0102030405060708", rsp_data); end
    // flush also releases a held result
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_compared++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL done_flush got=%b/%b exp=0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_async_reset();
    issue(64'h6008, 2'd3, 1'b0);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    // now in WAIT; assert reset between edges
    resetn = 1'b0;
    #1;
    n_compared++; if (dreq_valid !== 1'b0 || rsp_valid !== 1'b0 || rsp_misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_rst_ctrl got=%b/%b/%b exp=0/0/0", dreq_valid, rsp_valid, rsp_misalign); end
    n_compared++; if (dreq_addr !== 64'd0 || rsp_data !== 64'd0) begin n_mismatched++; $display("[TB] FAIL async_rst_data got=%h/%h exp=0/0", dreq_addr, rsp_data); end
    #2 resetn = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = 64'hDEAD;
    tick();
    dresp_data_ok = 1'b0;
    n_compared++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 64'd0) begin n_mismatched++; $display("[TB] FAIL stray_data got=%b/%b/%h exp=0/1/0", rsp_valid, req_ready, rsp_data); end
  endtask

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    resetn        = 1'b0;
    req_valid     = 1'b0;
    req_addr      = 64'd0;
    req_msize     = 2'd0;
    req_unsigned  = 1'b0;
    flush         = 1'b0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 64'd0;
    rsp_ready     = 1'b0;

    test_reset();
    test_byte();
    test_word_dword();
    test_misalign();
    test_stall_and_hold();
    test_flush();
    test_back_to_back();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
